// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register with the architectural NZVC flag register and EX/MEM forwarding value.
// Optional stall/flush event counters are enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_pipeline_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_W      = 5
`ifdef EXMEM_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_reg_data2,
  input  logic [DATA_WIDTH-1:0] ex_bl_write_data,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic [5:0]            ex_control_out,
  input  logic [3:0]            ex_flags,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [DATA_WIDTH-1:0] mem_reg_data2,
  output logic [DATA_WIDTH-1:0] mem_bl_write_data,
  output logic [REG_W-1:0]      mem_rd,
  output logic [4:0]            mem_control,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] ex_mem_forward_data,
  output logic [3:0]            current_flags
`ifdef EXMEM_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
`endif
);

  // The all-ones register index (XZR) doubles as "no destination".
  localparam logic [REG_W-1:0] NO_DEST = '1;

  logic       set_flags;
  logic [4:0] ctrl_no_setflags;

  // SetFlags (bit 1) is consumed by the flag register and never travels further down the pipe.
  assign set_flags        = ex_control_out[1];
  assign ctrl_no_setflags = {ex_control_out[5:2], ex_control_out[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_alu_result    <= '0;
      mem_reg_data2     <= '0;
      mem_bl_write_data <= '0;
      mem_rd            <= NO_DEST;
      mem_control       <= '0;
      mem_valid         <= 1'b0;
      current_flags     <= 4'b0000;
    end else if (flush) begin
      // Bubble: data cleared so a forwarded bubble reads as 0 with RegWrite low; flags untouched.
      mem_alu_result    <= '0;
      mem_reg_data2     <= '0;
      mem_bl_write_data <= '0;
      mem_rd            <= NO_DEST;
      mem_control       <= '0;
      mem_valid         <= 1'b0;
    end else if (!stall) begin
      mem_alu_result    <= ex_alu_result;
      mem_reg_data2     <= ex_reg_data2;
      mem_bl_write_data <= ex_bl_write_data;
      mem_rd            <= ex_rd;
      mem_control       <= ctrl_no_setflags;
      mem_valid         <= 1'b1;
      if (set_flags) begin
        current_flags <= ex_flags;
      end
    end
  end

  // BL writes the link value, so forward that instead of the (unused) ALU result.
  assign ex_mem_forward_data = mem_control[0] ? mem_bl_write_data : mem_alu_result;

`ifdef EXMEM_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // Flush outranks stall, so a combined request is counted as a flush only.
      if (flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + 1'b1;
      end
      if (stall && !flush && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Directed self-checking bench for ex_mem_pipeline_reg (counter checks when EXMEM_PERF_CNT_EN is defined).
module tb_ex_mem_pipeline_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [63:0] ex_alu_result, ex_reg_data2, ex_bl_write_data;
  logic [4:0]  ex_rd;
  logic [5:0]  ex_control_out;
  logic [3:0]  ex_flags;
  logic [63:0] mem_alu_result, mem_reg_data2, mem_bl_write_data, ex_mem_forward_data;
  logic [4:0]  mem_rd;
  logic [4:0]  mem_control;
  logic        mem_valid;
  logic [3:0]  current_flags;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  always #5 clk = ~clk;

  ex_mem_pipeline_reg dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .flush               (flush),
    .ex_alu_result       (ex_alu_result),
    .ex_reg_data2        (ex_reg_data2),
    .ex_bl_write_data    (ex_bl_write_data),
    .ex_rd               (ex_rd),
    .ex_control_out      (ex_control_out),
    .ex_flags            (ex_flags),
    .mem_alu_result      (mem_alu_result),
    .mem_reg_data2       (mem_reg_data2),
    .mem_bl_write_data   (mem_bl_write_data),
    .mem_rd              (mem_rd),
    .mem_control         (mem_control),
    .mem_valid           (mem_valid),
    .ex_mem_forward_data (ex_mem_forward_data),
    .current_flags       (current_flags)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_count       (stall_count),
    .flush_count         (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    n_edge++;
    $display("edge %0d: rst=%b stall=%b flush=%b -> rd=%0d ctrl=%b valid=%b alu=%h fwd=%h flags=%b",
             n_edge, reset, stall, flush, mem_rd, mem_control, mem_valid, mem_alu_result,
             ex_mem_forward_data, current_flags);
  endtask

  task automatic drive(input logic [63:0] alu, input logic [63:0] d2, input logic [63:0] bl,
                       input logic [4:0] rd, input logic [5:0] ctrl, input logic [3:0] fl);
    ex_alu_result    = alu;
    ex_reg_data2     = d2;
    ex_bl_write_data = bl;
    ex_rd            = rd;
    ex_control_out   = ctrl;
    ex_flags         = fl;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(64'hdead, 64'hbeef, 64'hcafe, 5'd7, 6'b111111, 4'b1111);

    // Reset state
    step(); step();
    check("rst_rd",    64'(mem_rd), 64'd31);
    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_ctrl",  64'(mem_control), 64'd0);
    check("rst_flags", 64'(current_flags), 64'd0);
    check("rst_alu",   mem_alu_result, 64'd0);
    check("rst_d2",    mem_reg_data2, 64'd0);
    check("rst_bl",    mem_bl_write_data, 64'd0);
    check("rst_fwd",   ex_mem_forward_data, 64'd0);

    // Plain load
    reset = 1'b0;
    drive(64'h10, 64'h0, 64'h0, 5'd3, 6'b100000, 4'b0000);
    step();
    check("ld_alu",   mem_alu_result, 64'h10);
    check("ld_rd",    64'(mem_rd), 64'd3);
    check("ld_ctrl",  64'(mem_control), 64'b10000);
    check("ld_valid", 64'(mem_valid), 64'd1);
    check("ld_fwd",   ex_mem_forward_data, 64'h10);
    check("ld_flags", 64'(current_flags), 64'd0);

    // Flags update only with SetFlags
    drive(64'h20, 64'h0, 64'h0, 5'd4, 6'b100010, 4'b1000);
    step();
    check("sf_flags1", 64'(current_flags), 64'b1000);
    check("sf_ctrl",   64'(mem_control), 64'b10000);
    drive(64'h30, 64'h0, 64'h0, 5'd5, 6'b100000, 4'b0100);
    step();
    check("sf_flags2", 64'(current_flags), 64'b1000);
    check("sf_alu",    mem_alu_result, 64'h30);

    // Stall for 3 cycles with changing inputs, including SetFlags
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(64'h99 + 64'(i), 64'h1, 64'h2, 5'd7 + 5'(i), 6'b111111, 4'b0011);
      step();
      check("stl_alu",   mem_alu_result, 64'h30);
      check("stl_rd",    64'(mem_rd), 64'd5);
      check("stl_ctrl",  64'(mem_control), 64'b10000);
      check("stl_valid", 64'(mem_valid), 64'd1);
      check("stl_flags", 64'(current_flags), 64'b1000);
    end

    // Valid store, then flush+stall on the same edge
    stall = 1'b0;
    drive(64'h40, 64'h55, 64'h0, 5'd9, 6'b010000, 4'b0001);
    step();
    check("st_ctrl", 64'(mem_control), 64'b01000);
    check("st_d2",   mem_reg_data2, 64'h55);
    flush = 1'b1; stall = 1'b1;
    drive(64'h44, 64'h66, 64'h0, 5'd10, 6'b010010, 4'b0110);
    step();
    check("fl_ctrl",  64'(mem_control), 64'd0);
    check("fl_valid", 64'(mem_valid), 64'd0);
    check("fl_rd",    64'(mem_rd), 64'd31);
    check("fl_flags", 64'(current_flags), 64'b1000);
    check("fl_alu",   mem_alu_result, 64'd0);
    check("fl_fwd",   ex_mem_forward_data, 64'd0);

`ifdef EXMEM_PERF_CNT_EN
    check("cnt_stall", 64'(stall_count), 64'd3);
    check("cnt_flush", 64'(flush_count), 64'd1);
`endif

    // BL forwards the link value
    flush = 1'b0; stall = 1'b0;
    drive(64'h0, 64'h0, 64'h104, 5'd30, 6'b100001, 4'b0000);
    step();
    check("bl_fwd",  ex_mem_forward_data, 64'h104);
    check("bl_ctrl", 64'(mem_control), 64'b10001);

    // XZR destination with RegWrite passes through unchanged
    drive(64'h77, 64'h0, 64'h104, 5'd31, 6'b100000, 4'b0000);
    step();
    check("xzr_rd",    64'(mem_rd), 64'd31);
    check("xzr_valid", 64'(mem_valid), 64'd1);
    check("xzr_fwd",   ex_mem_forward_data, 64'h77);

    // Reset beats flush and stall
    drive(64'h88, 64'h0, 64'h0, 5'd2, 6'b100010, 4'b1111);
    step();
    check("pre_flags", 64'(current_flags), 64'b1111);
    reset = 1'b1; flush = 1'b1; stall = 1'b1;
    step();
    check("rst2_flags", 64'(current_flags), 64'd0);
    check("rst2_rd",    64'(mem_rd), 64'd31);
    check("rst2_alu",   mem_alu_result, 64'd0);
`ifdef EXMEM_PERF_CNT_EN
    check("rst2_cnt",   64'(flush_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
